// File: rtl/dma_axi_rd_resp.sv
// AXI read-channel responder: queues AR requests, streams INCR bursts out of a 1-cycle-latency SRAM.
// Optional RD_ERR_CHK_EN: out-of-range addresses return SLVERR beats with zero data and no SRAM reads.
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module dma_axi_rd_resp #(
    parameter int ID_WIDTH   = `ID_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int MEM_AW     = 10,
    parameter int AR_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]   S_AXI_RID,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  mem_rd_en,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int OFF    = $clog2(DATA_WIDTH / 8);
    localparam int QAW    = $clog2(AR_DEPTH);
    localparam int STAGES = 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
    } ar_req_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_beat_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic                last;
        logic                err;
    } tag_t;

    typedef enum logic {IDLE, BURST} state_t;

    // ---------------- AR queue ----------------
    ar_req_t [AR_DEPTH-1:0] aq_mem;
    ar_req_t                aq_in, head;
    logic [QAW-1:0]         aq_wp, aq_rp;
    logic [QAW:0]           aq_cnt;
    logic                   aq_full, aq_empty, aq_push, aq_pop;

    assign aq_in         = '{id: S_AXI_ARID, addr: S_AXI_ARADDR, len: S_AXI_ARLEN};
    assign aq_full       = (aq_cnt == (QAW+1)'(AR_DEPTH));
    assign aq_empty      = (aq_cnt == '0);
    assign S_AXI_ARREADY = !aq_full;
    assign aq_push       = S_AXI_ARVALID && !aq_full;
    assign head          = aq_mem[aq_rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq_mem <= '0;
            aq_wp  <= '0;
            aq_rp  <= '0;
            aq_cnt <= '0;
        end else begin
            if (aq_push) begin
                aq_mem[aq_wp] <= aq_in;
                aq_wp         <= aq_wp + QAW'(1);
            end
            if (aq_pop)
                aq_rp <= aq_rp + QAW'(1);
            aq_cnt <= aq_cnt + (QAW+1)'(aq_push) - (QAW+1)'(aq_pop);
        end
    end

    logic head_err;
    logic unused_addr_bits;
`ifdef RD_ERR_CHK_EN
    assign head_err = |head.addr[ADDR_WIDTH-1:MEM_AW+OFF];
`else
    assign head_err = 1'b0;
`endif
    // Upper bits only matter with the range check; byte-offset bits never do.
    assign unused_addr_bits = ^{head.addr[ADDR_WIDTH-1:MEM_AW+OFF], head.addr[OFF-1:0]};

    // ---------------- burst engine ----------------
    state_t              state;
    logic [MEM_AW-1:0]   cur_addr;
    logic [7:0]          beat_cnt;
    logic [ID_WIDTH-1:0] cur_id;
    logic                cur_err;
    logic                issue, credit, r_pop;
    logic [1:0]          rb_cnt;
    logic [STAGES:1]     vld_q;
    logic [STAGES:0]     vld_pipe;
    tag_t                tag_s0, tag_q;

    assign r_pop = S_AXI_RVALID && S_AXI_RREADY;
    // Buffered + in-flight beats, less the one leaving this cycle, must stay under the 2 buffer slots.
    assign credit   = (3'(rb_cnt) + 3'(vld_q[STAGES])) < (3'd2 + 3'(r_pop));
    assign aq_pop   = (state == IDLE) && !aq_empty;
    assign issue    = (state == BURST) && credit;
    assign vld_pipe = {vld_q, issue};
    assign tag_s0   = '{id: cur_id, last: (beat_cnt == 8'd0), err: cur_err};

    assign mem_rd_en = issue && !cur_err;
    assign mem_addr  = cur_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            beat_cnt <= '0;
            cur_id   <= '0;
            cur_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!aq_empty) begin
                        cur_id   <= head.id;
                        cur_addr <= head.addr[OFF +: MEM_AW];
                        beat_cnt <= head.len;
                        cur_err  <= head_err;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (issue) begin
                        cur_addr <= cur_addr + MEM_AW'(1);
                        beat_cnt <= beat_cnt - 8'd1;
                        if (beat_cnt == 8'd0)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            tag_q <= tag_s0;
        end
    end

    // ---------------- R skid buffer ----------------
    r_beat_t [1:0] rb_mem;
    r_beat_t       rb_wr, rb_head;
    logic          rb_wp, rb_rp;

    always_comb begin
        rb_wr.id   = tag_q.id;
        rb_wr.last = tag_q.last;
        rb_wr.data = tag_q.err ? '0 : mem_rdata;
        rb_wr.resp = tag_q.err ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_mem <= '0;
            rb_wp  <= 1'b0;
            rb_rp  <= 1'b0;
            rb_cnt <= '0;
        end else begin
            if (vld_q[STAGES]) begin
                rb_mem[rb_wp] <= rb_wr;
                rb_wp         <= ~rb_wp;
            end
            if (r_pop)
                rb_rp <= ~rb_rp;
            rb_cnt <= rb_cnt + 2'(vld_q[STAGES]) - 2'(r_pop);
        end
    end

    assign rb_head      = rb_mem[rb_rp];
    assign S_AXI_RVALID = (rb_cnt != 2'd0);
    assign S_AXI_RID    = rb_head.id;
    assign S_AXI_RDATA  = rb_head.data;
    assign S_AXI_RRESP  = rb_head.resp;
    assign S_AXI_RLAST  = rb_head.last;

endmodule

// File: tb/tb_dma_axi_rd_resp.sv
// Bench for dma_axi_rd_resp: the AR driver pushes expected beats/SRAM addresses, a negedge monitor checks them.
module tb_dma_axi_rd_resp;
    localparam int IDW = 4, AW = 32, DW = 32, MAW = 10, DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [IDW-1:0] S_AXI_ARID = '0;
    logic [AW-1:0]  S_AXI_ARADDR = '0;
    logic [7:0]     S_AXI_ARLEN = '0;
    logic           S_AXI_ARVALID = 1'b0;
    logic           S_AXI_ARREADY;
    logic [IDW-1:0] S_AXI_RID;
    logic [DW-1:0]  S_AXI_RDATA;
    logic [1:0]     S_AXI_RRESP;
    logic           S_AXI_RLAST;
    logic           S_AXI_RVALID;
    logic           S_AXI_RREADY = 1'b0;
    logic           mem_rd_en;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_rdata = '0;

    dma_axi_rd_resp #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW), .AR_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
    } exp_beat_t;

    logic [DW-1:0]  sram [0:(1<<MAW)-1];
    exp_beat_t      sb[$];
    logic [MAW-1:0] exp_addr[$];
    exp_beat_t      e;
    logic [38:0]    held;
    logic           stall_q = 1'b0;
    logic           occ_on = 1'b0;
    logic           bp_on = 1'b0;
    int n_cmp = 0, n_err = 0;
    int cyc = 0, ar_cyc = 0, nbeats = 0, first_hs = -1, last_hs = -1;
    int occ = 0, rd_cnt = 0, bp_i = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rdata <= sram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                rd_cnt++;
                chk("rd_expected", 64'(exp_addr.size() != 0), 1);
                if (exp_addr.size() != 0) chk("mem_addr", mem_addr, exp_addr.pop_front());
            end
            if (stall_q) begin
                chk("hold_rvalid", S_AXI_RVALID, 1);
                chk("hold_beat", {S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST}, held);
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                chk("beat_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rid", S_AXI_RID, e.id);
                    chk("rdata", S_AXI_RDATA, e.data);
                    chk("rresp", S_AXI_RRESP, e.resp);
                    chk("rlast", S_AXI_RLAST, e.last);
                end
                nbeats++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (occ_on) begin
                chk("outstanding_le2", 64'(occ <= 2), 1);
                occ = occ + int'(mem_rd_en) - int'(S_AXI_RVALID && S_AXI_RREADY);
            end
            stall_q = S_AXI_RVALID && !S_AXI_RREADY;
            held    = {S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST};
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic ar_send(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len);
        int t;
        logic err;
        logic [MAW-1:0] w;
        exp_beat_t b;
        S_AXI_ARID    = id;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = 8'(len);
        S_AXI_ARVALID = 1'b1;
        t = 0;
        @(negedge clk);
        while (!S_AXI_ARREADY && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ar_accept", S_AXI_ARREADY, 1);
        ar_cyc = cyc;
`ifdef RD_ERR_CHK_EN
        err = (addr[AW-1:MAW+2] != '0);
`else
        err = 1'b0;
`endif
        for (int k = 0; k <= len; k++) begin
            w      = addr[MAW+1:2] + MAW'(k);
            b.id   = id;
            b.data = err ? '0 : sram[w];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (k == len);
            sb.push_back(b);
            if (!err) exp_addr.push_back(w);
        end
        @(posedge clk);
        #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        int n0, c1, t;
        for (int i = 0; i < (1 << MAW); i++) sram[i] = 32'hC0DE_0000 | 32'(i);
        sram[5] = 32'hA5A5_A5A5;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", S_AXI_ARREADY, 1);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_rlast", S_AXI_RLAST, 0);
        chk("rst_rid", S_AXI_RID, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_rresp", S_AXI_RRESP, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single beat, latency
        S_AXI_RREADY = 1'b1;
        first_hs = -1; n0 = nbeats;
        ar_send(4'd3, 32'(5 * (DW / 8)), 0);
        wait_drain("single_drain", 50);
        chk("single_latency", 64'(first_hs - ar_cyc), 4);
        chk("single_count", 64'(nbeats - n0), 1);

        // full 256-beat burst at 1 beat/cycle
        first_hs = -1; n0 = nbeats;
        ar_send(4'd7, 32'h0, 255);
        wait_drain("full_drain", 600);
        chk("full_count", 64'(nbeats - n0), 256);
        chk("full_span", 64'(last_hs - first_hs), 255);
        chk("full_addr_left", exp_addr.size(), 0);

        // backpressure 1,0,0 repeating
        occ = 0; occ_on = 1'b1; bp_on = 1'b1; bp_i = 0;
        fork
            while (bp_on) begin
                S_AXI_RREADY = (bp_i % 3 == 0);
                bp_i++;
                @(posedge clk);
                #1;
            end
        join_none
        n0 = nbeats;
        ar_send(4'd9, 32'h200, 7);
        wait_drain("bp_drain", 200);
        bp_on = 1'b0; occ_on = 1'b0;
        @(posedge clk);
        #3;
        S_AXI_RREADY = 1'b0;
        chk("bp_count", 64'(nbeats - n0), 8);

        // queue full: 5 back-to-back requests with RREADY low
        first_hs = -1; n0 = nbeats; c1 = 0;
        for (int k = 1; k <= 5; k++) begin
            ar_send(IDW'(k), AW'(k * 256), 3);
            if (k == 1) c1 = ar_cyc;
        end
        chk("qf_b2b", 64'(ar_cyc - c1), 4);
        chk("qf_full", S_AXI_ARREADY, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("qf_still_full", S_AXI_ARREADY, 0);
        chk("qf_held_beats", 64'(nbeats - n0), 0);
        S_AXI_RREADY = 1'b1;
        wait_drain("qf_drain", 200);
        chk("qf_count", 64'(nbeats - n0), 20);
        chk("qf_span_le23", 64'((last_hs - first_hs) <= 23), 1);

        // address wrap, then reset after beat 2
        n0 = nbeats;
        ar_send(4'd6, 32'(((1 << MAW) - 2) * 4), 3);
        t = 0;
        while (nbeats < n0 + 2 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("wrap_addrs_issued", exp_addr.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", S_AXI_RVALID, 0);
        chk("rst_mid_rd_en", mem_rd_en, 0);
        sb.delete();
        exp_addr.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_beats", 64'(nbeats - n0), 2);
        chk("post_rst_rvalid", S_AXI_RVALID, 0);

        // out-of-range address (bit MEM_AW+2)
        n0 = nbeats; rd_cnt = 0;
        ar_send(4'd2, 32'h1000, 2);
        wait_drain("err_drain", 50);
        repeat (3) @(posedge clk);
        #1;
`ifdef RD_ERR_CHK_EN
        chk("err_rd_cnt", rd_cnt, 0);
`else
        chk("err_rd_cnt", rd_cnt, 3);
`endif
        chk("err_count", 64'(nbeats - n0), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, limit 200000", $time);
        $fatal(1, "watchdog");
    end
endmodule
